// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer: FSM state encoding,
// serve-direction / player identifiers and default match parameters.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        PAUSED,
        POINT,
        GAME_OVER
    } state_t;

    // serve_dir encoding
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // winner / pending-scorer encoding
    localparam logic PLAYER_LEFT  = 1'b0;
    localparam logic PLAYER_RIGHT = 1'b1;

    localparam int DEF_WIN_SCORE          = 5;
    localparam int DEF_SERVE_DELAY_FRAMES = 120;
    localparam int DEF_SCORE_W            = 4;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a level input.
//   clk    : system clock
//   reset  : synchronous, active-low
//   din    : level input
//   pulse  : high for the cycle where din is 1 and was 0 last cycle
// The history flop resets to RST_VAL; with RST_VAL=1 an input held high
// through reset release does not look like a fresh edge.
module rise_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic din_q;
    logic din_d;

    always_comb din_d = din;

    always_ff @(posedge clk) begin
        if (!reset) din_q <= RST_VAL;
        else        din_q <= din_d;
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for two-player Pong.
//   clk, reset      : clock, synchronous active-low reset
//   frame_tick      : one-cycle pulse per video frame
//   start, pause    : debounced button levels (edge detected here)
//   left/right_wall_hit : ball in a score area (levels, edge detected here)
//   play_en         : ball motion enable
//   ball_serve      : one-cycle re-centre/launch pulse
//   serve_dir       : 0 launch left, 1 launch right
//   score_l/score_r : player scores
//   game_over/winner: match finished / who won (0 left, 1 right)
// All outputs are flops loaded from the next-state decode, so they track
// the state register without a cycle of lag.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE          = DEF_WIN_SCORE,
    parameter int SERVE_DELAY_FRAMES = DEF_SERVE_DELAY_FRAMES,
    parameter int SCORE_W            = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               left_wall_hit,
    input  logic               right_wall_hit,
    output logic               play_en,
    output logic               ball_serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner
);

    localparam int CNT_W = $clog2(SERVE_DELAY_FRAMES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

    logic start_p, pause_p, lh_p, rh_p;

    rise_edge_det #(.RST_VAL(1'b1)) u_start_edge (.clk(clk), .reset(reset), .din(start),          .pulse(start_p));
    rise_edge_det #(.RST_VAL(1'b1)) u_pause_edge (.clk(clk), .reset(reset), .din(pause),          .pulse(pause_p));
    rise_edge_det #(.RST_VAL(1'b1)) u_lh_edge    (.clk(clk), .reset(reset), .din(left_wall_hit),  .pulse(lh_p));
    rise_edge_det #(.RST_VAL(1'b1)) u_rh_edge    (.clk(clk), .reset(reset), .din(right_wall_hit), .pulse(rh_p));

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [SCORE_W-1:0] score_l_q,    score_l_d;
    logic [SCORE_W-1:0] score_r_q,    score_r_d;
    logic               scorer_q,     scorer_d;
    logic               serve_dir_q,  serve_dir_d;
    logic               winner_q,     winner_d;
    logic               play_en_q,    play_en_d;
    logic               ball_serve_q, ball_serve_d;
    logic               game_over_q,  game_over_d;

    logic               lh_ok, rh_ok;
    logic [SCORE_W-1:0] score_inc;

    // The ball is being re-centred during the serve cycle, so any hit edge
    // seen then is stale and must not score.
    assign lh_ok = lh_p & ~ball_serve_q;
    assign rh_ok = rh_p & ~ball_serve_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        scorer_d    = scorer_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        score_inc   = '0;

        case (state_q)
            IDLE: begin
                if (start_p) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    cnt_d     = '0;
                    state_d   = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                // Counter is left at zero on exit so a let can re-enter
                // SERVE_WAIT and get the full delay again.
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (lh_ok && rh_ok) begin
                    state_d = SERVE_WAIT;
                end else if (rh_ok) begin
                    scorer_d = PLAYER_LEFT;
                    state_d  = POINT;
                end else if (lh_ok) begin
                    scorer_d = PLAYER_RIGHT;
                    state_d  = POINT;
                end else if (pause_p) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (pause_p) state_d = PLAY;
            end
            POINT: begin
                if (scorer_q == PLAYER_LEFT) begin
                    score_inc   = score_l_q + 1'b1;
                    score_l_d   = score_inc;
                    serve_dir_d = DIR_RIGHT;
                end else begin
                    score_inc   = score_r_q + 1'b1;
                    score_r_d   = score_inc;
                    serve_dir_d = DIR_LEFT;
                end
                if (score_inc == WIN_VAL) begin
                    winner_d = scorer_q;
                    state_d  = GAME_OVER;
                end else begin
                    cnt_d   = '0;
                    state_d = SERVE_WAIT;
                end
            end
            GAME_OVER: begin
                if (start_p) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = DIR_LEFT;
                    cnt_d       = '0;
                    state_d     = SERVE_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        play_en_d    = (state_d == PLAY);
        ball_serve_d = (state_q == SERVE_WAIT) && (state_d == PLAY);
        game_over_d  = (state_d == GAME_OVER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            scorer_q     <= PLAYER_LEFT;
            serve_dir_q  <= DIR_LEFT;
            winner_q     <= PLAYER_LEFT;
            play_en_q    <= 1'b0;
            ball_serve_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            scorer_q     <= scorer_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            play_en_q    <= play_en_d;
            ball_serve_q <= ball_serve_d;
            game_over_q  <= game_over_d;
        end
    end

    assign play_en    = play_en_q;
    assign ball_serve = ball_serve_q;
    assign serve_dir  = serve_dir_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule
